// File: rtl/tcm_dual_port_controller.sv
// Dual-port tightly-coupled memory: port A read-only fetch, port B load/store.
// Word-interleaved banks with per-bank arbitration and a LATENCY-deep response pipeline.
module tcm_dual_port_controller #(
  parameter int unsigned VA_WIDTH = 14,
  parameter int unsigned BANKS    = 2,
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned ARB_RR   = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [VA_WIDTH-1:0] a_addr,
  input  logic [1:0]          a_acc,
  input  logic                a_req,
  output logic [31:0]         a_rdata,
  output logic                a_resp,
  output logic                a_fault,
  input  logic [VA_WIDTH-1:0] b_addr,
  input  logic                b_w_rb,
  input  logic [1:0]          b_acc,
  input  logic [31:0]         b_wdata,
  input  logic                b_req,
  output logic [31:0]         b_rdata,
  output logic                b_resp,
  output logic                b_fault
);

  localparam int unsigned LOG2B = $clog2(BANKS);
  localparam int unsigned BW    = (LOG2B > 0) ? LOG2B : 1;
  localparam int unsigned IDX_W = VA_WIDTH - 2 - LOG2B;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned PA    = 0;
  localparam int unsigned PB    = 1;

  localparam logic [1:0] ACC_1B = 2'd0;
  localparam logic [1:0] ACC_2B = 2'd1;
  localparam logic [1:0] ACC_4B = 2'd2;

  typedef enum logic {PTR_A, PTR_B} rr_ptr_e;

  logic [31:0]         mem [BANKS][DEPTH];

  logic [VA_WIDTH-1:0] addr_w    [2];
  logic [1:0]          acc_w     [2];
  logic [BW-1:0]       bank_w    [2];
  logic [IDX_W-1:0]    idx_w     [2];
  logic [1:0]          sel_w     [2];
  logic [31:0]         rd_word_w [2];
  logic [1:0]          req_w;
  logic [1:0]          rd_w;
  logic [1:0]          invalid_w;
  logic [1:0]          valid_w;
  logic [1:0]          busy_w;
  logic [1:0]          accept_w;
  logic                conflict_w;
  logic                grant_b_w;
  logic [3:0]          wbe_w;
  logic [31:0]         wdata_w;

  rr_ptr_e             ptr_q, ptr_d;
  logic [LATENCY-1:0]  vpipe_q [2];
  logic [LATENCY-1:0]  rpipe_q [2];
  logic [31:0]         dpipe_q [2][LATENCY];

  function automatic logic [31:0] rotr_bytes(input logic [31:0] w, input logic [1:0] sel);
    logic [31:0] r;
    case (sel)
      2'd1:    r = {w[7:0],  w[31:8]};
      2'd2:    r = {w[15:0], w[31:16]};
      2'd3:    r = {w[23:0], w[31:24]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign addr_w[PA] = a_addr;
  assign addr_w[PB] = b_addr;
  assign acc_w[PA]  = a_acc;
  assign acc_w[PB]  = b_acc;
  assign req_w      = {b_req, a_req};
  assign rd_w       = {~b_w_rb, 1'b1};

  always_comb begin
    invalid_w = '0;
    valid_w   = '0;
    busy_w    = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      busy_w[p]    = |vpipe_q[p];
      invalid_w[p] = (acc_w[p] == 2'd3)
                   | (addr_w[p][0] & (acc_w[p] != ACC_1B))
                   | ((addr_w[p][1:0] == 2'd2) & (acc_w[p] == ACC_4B));
      valid_w[p]   = req_w[p] & ~invalid_w[p] & ~busy_w[p];
      bank_w[p]    = (BANKS > 1) ? addr_w[p][2 +: BW] : '0;
      idx_w[p]     = addr_w[p][VA_WIDTH-1 -: IDX_W];
      case (acc_w[p])
        ACC_1B:  sel_w[p] = addr_w[p][1:0];
        ACC_2B:  sel_w[p] = {addr_w[p][1], 1'b0};
        default: sel_w[p] = '0;
      endcase
      rd_word_w[p] = rotr_bytes(mem[bank_w[p]][idx_w[p]], sel_w[p]);
    end
  end

  // Only requests that would otherwise be accepted take part in arbitration.
  always_comb begin
    conflict_w   = valid_w[PA] & valid_w[PB] & (bank_w[PA] == bank_w[PB]);
    grant_b_w    = (ARB_RR == 0) || (ptr_q == PTR_B);
    accept_w[PA] = valid_w[PA] & ~(conflict_w & grant_b_w);
    accept_w[PB] = valid_w[PB] & ~(conflict_w & ~grant_b_w);
    ptr_d        = ptr_q;
    if ((ARB_RR != 0) && conflict_w) begin
      ptr_d = (ptr_q == PTR_A) ? PTR_B : PTR_A;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    wbe_w   = '1;
    wdata_w = b_wdata;
    case (b_acc)
      ACC_1B: begin
        wbe_w   = 4'b0001 << b_addr[1:0];
        wdata_w = {4{b_wdata[7:0]}};
      end
      ACC_2B: begin
        wbe_w   = b_addr[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{b_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept_w[PB] && b_w_rb) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wbe_w[i]) begin
          mem[bank_w[PB]][idx_w[PB]][8*i +: 8] <= wdata_w[8*i +: 8];
        end
      end
    end
  end

  // The last data stage doubles as the rdata holding register: it loads only for reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned p = 0; p < 2; p++) begin
        vpipe_q[p] <= '0;
        rpipe_q[p] <= '0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
          dpipe_q[p][k] <= '0;
        end
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        vpipe_q[p] <= (vpipe_q[p] << 1) | LATENCY'(accept_w[p]);
        rpipe_q[p] <= (rpipe_q[p] << 1) | LATENCY'(rd_w[p]);
        if (accept_w[p] && ((LATENCY > 1) || rd_w[p])) begin
          dpipe_q[p][0] <= rd_word_w[p];
        end
        for (int unsigned k = 1; k < LATENCY; k++) begin
          if (vpipe_q[p][k-1] && ((k < LATENCY - 1) || rpipe_q[p][k-1])) begin
            dpipe_q[p][k] <= dpipe_q[p][k-1];
          end
        end
      end
    end
  end

  assign a_resp  = vpipe_q[PA][LATENCY-1];
  assign b_resp  = vpipe_q[PB][LATENCY-1];
  assign a_rdata = dpipe_q[PA][LATENCY-1];
  assign b_rdata = dpipe_q[PB][LATENCY-1];
  assign a_fault = req_w[PA] & invalid_w[PA];
  assign b_fault = req_w[PB] & invalid_w[PB];

endmodule

// File: tb/tb_tcm_dual_port_controller.sv
// Randomised bench for tcm_dual_port_controller against a byte-array reference model
// with per-cycle expectations for resp, rdata and fault on both ports.
module tb_tcm_dual_port_controller;

  localparam int unsigned VA   = 10;
  localparam int unsigned NB   = 2;
  localparam int unsigned LAT  = 2;
  localparam int unsigned RR   = 1;
  localparam int unsigned MEMB = 1 << VA;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [VA-1:0] a_addr, b_addr;
  logic [1:0]    a_acc, b_acc;
  logic          a_req, b_req, b_w_rb;
  logic [31:0]   b_wdata;
  logic [31:0]   a_rdata, b_rdata;
  logic          a_resp, b_resp, a_fault, b_fault;

  tcm_dual_port_controller #(
    .VA_WIDTH(VA),
    .BANKS   (NB),
    .LATENCY (LAT),
    .ARB_RR  (RR)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .a_addr (a_addr),
    .a_acc  (a_acc),
    .a_req  (a_req),
    .a_rdata(a_rdata),
    .a_resp (a_resp),
    .a_fault(a_fault),
    .b_addr (b_addr),
    .b_w_rb (b_w_rb),
    .b_acc  (b_acc),
    .b_wdata(b_wdata),
    .b_req  (b_req),
    .b_rdata(b_rdata),
    .b_resp (b_resp),
    .b_fault(b_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            vld;
    bit            wr;
    logic [1:0]    acc;
    logic [VA-1:0] addr;
    logic [31:0]   wdata;
  } txn_t;

  txn_t        cur [2];
  txn_t        qa [$];
  txn_t        qb [$];
  logic [7:0]  mdl [MEMB];
  bit          busy [2];
  int          resp_cyc [2];
  logic [31:0] exp_rd [2];
  logic [31:0] hold [2];
  bit          rr_b;
  bit          rand_mode;
  int          cyc;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bad_acc(input logic [1:0] acc, input logic [VA-1:0] addr);
    int unsigned a;
    int unsigned n;
    if (acc == 2'd3) return 1'b1;
    a = 32'(addr);
    n = 1 << acc;
    return (a % n) != 0;
  endfunction

  function automatic int unsigned bank_of(input logic [VA-1:0] addr);
    int unsigned a;
    a = 32'(addr);
    return (a / 4) % NB;
  endfunction

  // Addressed bytes land in the low lanes; the rest of the word follows in rotation.
  function automatic logic [31:0] model_read(input logic [VA-1:0] addr);
    int unsigned a;
    int unsigned base;
    logic [31:0] r;
    a    = 32'(addr);
    base = a - (a % 4);
    for (int unsigned j = 0; j < 4; j++) begin
      r[8*j +: 8] = mdl[base + ((a % 4 + j) % 4)];
    end
    return r;
  endfunction

  task automatic model_write(input logic [VA-1:0] addr, input logic [1:0] acc, input logic [31:0] wd);
    int unsigned a;
    int unsigned n;
    a = 32'(addr);
    n = 1 << acc;
    for (int unsigned j = 0; j < n; j++) begin
      mdl[a + j] = wd[8*j +: 8];
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [1:0] acc, input int unsigned addr,
                              input logic [31:0] wd);
    txn_t t;
    t.vld   = 1'b1;
    t.wr    = wr;
    t.acc   = acc;
    t.addr  = VA'(addr);
    t.wdata = wd;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit allow_wr);
    txn_t t;
    t.vld   = 1'b1;
    t.wr    = allow_wr && ($urandom_range(0, 1) == 1);
    t.acc   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    t.addr  = VA'($urandom_range(0, MEMB - 1));
    if (t.acc != 2'd3 && $urandom_range(0, 7) != 0) begin
      t.addr = t.addr & ~VA'((1 << t.acc) - 1);
    end
    t.wdata = $urandom;
    return t;
  endfunction

  task automatic next_txn(input int p);
    if (p == 0 && qa.size() > 0) cur[0] = qa.pop_front();
    else if (p == 1 && qb.size() > 0) cur[1] = qb.pop_front();
    else if (rand_mode && $urandom_range(0, 3) != 0) cur[p] = rand_txn(p == 1);
    else cur[p].vld = 1'b0;
  endtask

  task automatic drive();
    a_req   = cur[0].vld;
    a_addr  = cur[0].addr;
    a_acc   = cur[0].acc;
    b_req   = cur[1].vld;
    b_addr  = cur[1].addr;
    b_acc   = cur[1].acc;
    b_w_rb  = cur[1].wr;
    b_wdata = cur[1].wdata;
  endtask

  task automatic run_cycle();
    bit          invl [2];
    bit          cand [2];
    bit          er [2];
    bit          done [2];
    int          win;
    string       pre;
    logic        o_fault, o_resp;
    logic [31:0] o_rd;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      pre     = (p == 0) ? "a" : "b";
      o_fault = (p == 0) ? a_fault : b_fault;
      o_resp  = (p == 0) ? a_resp : b_resp;
      o_rd    = (p == 0) ? a_rdata : b_rdata;
      invl[p] = cur[p].vld && bad_acc(cur[p].acc, cur[p].addr);
      er[p]   = busy[p] && (resp_cyc[p] == cyc);
      if (er[p] && !cur[p].wr) hold[p] = exp_rd[p];
      check({pre, "_fault"}, 32'(o_fault), 32'(invl[p]));
      check({pre, "_resp"}, 32'(o_resp), 32'(er[p]));
      check({pre, "_rdata"}, o_rd, hold[p]);
      cand[p] = cur[p].vld && !invl[p] && !busy[p];
      done[p] = invl[p] || er[p];
    end
    if (cand[0] && cand[1] && bank_of(cur[0].addr) == bank_of(cur[1].addr)) begin
      win  = rr_b ? 1 : 0;
      rr_b = !rr_b;
      cand[1 - win] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (er[p]) busy[p] = 1'b0;
      if (cand[p]) begin
        busy[p]     = 1'b1;
        resp_cyc[p] = cyc + LAT;
        if (cur[p].wr) model_write(cur[p].addr, cur[p].acc, cur[p].wdata);
        else exp_rd[p] = model_read(cur[p].addr);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (done[p] || !cur[p].vld) next_txn(p);
    end
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((cur[0].vld || cur[1].vld || busy[0] || busy[1] || qa.size() != 0 || qb.size() != 0)
           && n < 1000) begin
      run_cycle();
      n++;
    end
    check({"drain_", tag}, 32'(n < 1000), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rr_b      = 1'b0;
    rand_mode = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cur[p].vld = 1'b0;
      cur[p].wr  = 1'b0;
      cur[p].acc = 2'd0;
      cur[p].addr = '0;
      cur[p].wdata = '0;
      busy[p] = 1'b0;
      hold[p] = '0;
      exp_rd[p] = '0;
      resp_cyc[p] = 0;
    end
    drive();
    repeat (2) @(negedge clk);
    check("rst_a_resp", 32'(a_resp), 32'd0);
    check("rst_b_resp", 32'(b_resp), 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    for (int unsigned w = 0; w < MEMB / 4; w++) qb.push_back(mk(1'b1, 2'd2, w * 4, $urandom));
    drain("preload");

    qb.push_back(mk(1'b1, 2'd2, 32'h10, 32'hDEADBEEF));
    drain("w_deadbeef");
    qa.push_back(mk(1'b0, 2'd2, 32'h10, '0));
    drain("r_deadbeef");
    check("a_read_deadbeef", a_rdata, 32'hDEADBEEF);

    qb.push_back(mk(1'b1, 2'd0, 32'h13, 32'h0000005A));
    qb.push_back(mk(1'b0, 2'd1, 32'h12, '0));
    drain("subword");
    check("b_half_5aad", 32'(b_rdata[15:0]), 32'h5AAD);

    // Same-bank pairs: grants must alternate A, B, A, B.
    repeat (4) begin
      qa.push_back(mk(1'b0, 2'd2, 32'h00, '0));
      qb.push_back(mk(1'b0, 2'd2, 32'h20, '0));
      drain("conflict");
    end

    qa.push_back(mk(1'b0, 2'd2, 32'h04, '0));
    qb.push_back(mk(1'b0, 2'd2, 32'h08, '0));
    drain("parallel");

    qa.push_back(mk(1'b0, 2'd1, 32'h01, '0));
    qb.push_back(mk(1'b1, 2'd2, 32'h02, 32'h12345678));
    drain("faults");
    qa.push_back(mk(1'b0, 2'd2, 32'h00, '0));
    drain("fault_readback");

    rand_mode = 1'b1;
    repeat (1500) run_cycle();
    rand_mode = 1'b0;
    drain("random");

    // Reset one cycle after a port B read is accepted: its response must never appear.
    b_addr  = VA'(32'h40);
    b_acc   = 2'd2;
    b_w_rb  = 1'b0;
    b_req   = 1'b1;
    @(negedge clk);
    check("midrst_b_fault", 32'(b_fault), 32'd0);
    @(posedge clk);
    #1;
    b_req = 1'b0;
    rstn  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_b_resp", 32'(b_resp), 32'd0);
      check("midrst_b_rdata", b_rdata, 32'd0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (LAT + 3) begin
      @(negedge clk);
      check("postrst_b_resp", 32'(b_resp), 32'd0);
    end
    @(posedge clk);
    #1;
    rr_b = 1'b0;
    for (int p = 0; p < 2; p++) begin
      busy[p]    = 1'b0;
      hold[p]    = '0;
      cur[p].vld = 1'b0;
    end
    drive();

    qb.push_back(mk(1'b0, 2'd2, 32'h40, '0));
    qa.push_back(mk(1'b0, 2'd0, 32'h47, '0));
    drain("postrst_read");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
